// File: rtl/mem_ram_bytelane.sv
// Byte-lane data memory for the MEM stage: byte/half/word loads and stores, with an
// optional zero-fill after reset and a registered, one-cycle-latency completion strobe.
module mem_ram_bytelane #(
    parameter int ADDR_WIDTH     = 12,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           MDin,
    output logic                  ready,
    output logic                  rvalid,
    output logic [31:0]           data,
    output logic                  err
);

    localparam int IW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IW;

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    state_t         state, state_next;
    logic [IW-1:0]  idx, idx_next;

    logic [31:0]    mem [DEPTH];
    logic [31:0]    rd_word;

    logic           accept;
    logic           illegal;
    logic [IW-1:0]  word_idx;
    logic [1:0]     off;
    logic [3:0]     be;
    logic [31:0]    wdata;

    logic           wr_en;
    logic [IW-1:0]  wr_idx;
    logic [3:0]     wr_be;
    logic [31:0]    wr_data;

    // Request captured at the accept edge, completed one edge later.
    logic           p_valid, p_load, p_err, p_sext;
    logic [1:0]     p_off, p_size;
    logic [31:0]    shifted;
    logic [31:0]    load_fmt;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        if (state == S_CLEAR) begin
            idx_next = idx + IW'(1);
            if (&idx) state_next = S_IDLE;
        end
    end

    always_comb begin
        word_idx = addr[ADDR_WIDTH-1:2];
        off      = addr[1:0];
        accept   = req & ready;
        illegal  = (size == 2'b11)
                 | ((size == 2'b01) & addr[0])
                 | ((size == 2'b10) & (|addr[1:0]));
        be = 4'b0000;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = addr[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        wdata = MDin << {off, 3'b000};
    end

    // The clear sequence and CPU stores share the single write port.
    always_comb begin
        wr_en   = (state == S_CLEAR) | (accept & we & ~illegal);
        wr_idx  = (state == S_CLEAR) ? idx : word_idx;
        wr_be   = (state == S_CLEAR) ? 4'b1111 : be;
        wr_data = (state == S_CLEAR) ? 32'h0 : wdata;
    end

    // NOTE: the memory array has no reset; zero-fill is done by the CLEAR sequence instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        if (accept & ~we) rd_word <= mem[word_idx];
    end

    always_comb begin
        shifted  = rd_word >> {p_off, 3'b000};
        load_fmt = rd_word;
        case (p_size)
            2'b00:   load_fmt = {{24{p_sext & shifted[7]}}, shifted[7:0]};
            2'b01:   load_fmt = {{16{p_sext & shifted[15]}}, shifted[15:0]};
            default: load_fmt = rd_word;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RESET_STATE;
            idx     <= '0;
            ready   <= 1'b0;
            p_valid <= 1'b0;
            p_load  <= 1'b0;
            p_err   <= 1'b0;
            p_sext  <= 1'b0;
            p_off   <= 2'b00;
            p_size  <= 2'b00;
            rvalid  <= 1'b0;
            err     <= 1'b0;
            data    <= 32'h0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            ready   <= (state_next == S_IDLE);
            p_valid <= accept;
            p_load  <= ~we;
            p_err   <= illegal;
            p_sext  <= sign_ext;
            p_off   <= off;
            p_size  <= size;
            rvalid  <= p_valid;
            err     <= p_valid & p_err;
            if (p_valid & p_load & ~p_err) data <= load_fmt;
        end
    end

endmodule

// File: doc/mem_ram_bytelane.md
# mem_ram_bytelane

Parametrised data memory for the CPU's MEM stage. It supports byte, halfword and word loads and stores through little-endian byte lanes, and optionally zero-fills its contents after reset. Loads return through a registered output with a one-cycle `rvalid` strobe. Illegal or misaligned accesses are rejected and flagged on `err`.

## Interface
- `ADDR_WIDTH`, default 12: byte-address width. Word depth `DEPTH = 2**(ADDR_WIDTH-2)`. Legal range is 3..22.
- `CLEAR_ON_RESET`, default 1: when 1, all words are zero-filled after reset release. When 0, contents are left undefined.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request; sampled only when `ready`=1.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `sign_ext`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `addr`  in  ADDR_WIDTH  byte address.
- `MDin`  in  32  store data; the value is taken from the low bits (`[7:0]`, `[15:0]` or `[31:0]`).
- `ready`  out  1  block is in IDLE and accepts requests.
- `rvalid`  out  1  one-cycle completion strobe for every accepted request.
- `data`  out  32  formatted load result; holds its value until the next successful load.
- `err`  out  1  qualifies `rvalid`: the access was illegal or misaligned.

## Operation
- **States.**
  - CLEAR: `ready`=0. An index counter writes 0 to word `idx` and increments. After writing `DEPTH-1` the block goes to IDLE.
  - IDLE: `ready`=1.
  - Reset enters CLEAR if `CLEAR_ON_RESET`=1, otherwise IDLE.
- **Accept.** A request is accepted on an edge where `req`=1 and `ready`=1. When `ready`=0, `req` is ignored: no write, no `rvalid`.
- **Fields.**
  - Word index = `addr[ADDR_WIDTH-1:2]`.
  - Lane offset = `addr[1:0]`.
  - Lane 0 = bits `[7:0]`.
- **Legality.** An access is illegal if:
  - `size`=11, or
  - `size`=01 and `addr[0]`=1, or
  - `size`=10 and `addr[1:0]`≠00.

  An illegal access performs no write, leaves `data` unchanged, and produces `rvalid`=1 and `err`=1.
- **Store.** Write enables:
  - Byte: one lane, selected by `addr[1:0]`.
  - Halfword: lanes {1,0} or {3,2}, selected by `addr[1]`.
  - Word: all lanes.

  Each enabled lane receives the corresponding byte of `MDin` shifted to the lane position. Other lanes are unchanged.
- **Load.** The selected byte or halfword is right-aligned. It is extended to 32 bits with its MSB if `sign_ext`=1, otherwise with zeros. A word load ignores `sign_ext`. The result is registered into `data`.
- **Completion.** Stores and legal loads produce `rvalid`=1 and `err`=0. `data` is updated only by legal loads.
- **Reset mid-operation.**
  - Asserting `rst` at any time forces all outputs to their reset values immediately.
  - A clear in progress restarts from index 0 after release.
  - A request in flight is dropped: no `rvalid`.

## Timing
- **Reset values** (while `rst`=0): `ready`=0, `rvalid`=0, `err`=0, `data`=0, `idx`=0.
- **`CLEAR_ON_RESET`=1.**
  - Word k is written at edge k+1 after release, for k = 0..DEPTH-1.
  - `ready` rises at edge DEPTH.
  - The first request is accepted at edge DEPTH+1.
- **`CLEAR_ON_RESET`=0.** `ready` rises at edge 1 after release.
- **Latency.**
  - A request accepted at edge N gives `rvalid`, `err` and `data` valid after edge N+1.
  - `rvalid` is high for exactly one cycle unless another request is accepted at edge N+1.
- **Throughput.**
  - One request per cycle; back-to-back requests give a continuous `rvalid`.
  - `ready` stays 1 in IDLE; there is no back-pressure.
- **Read-after-write.**
  - A store at edge N followed by a load at edge N+1 to the same word returns the new data after edge N+2.
  - The memory write occurs at the accept edge.

## Test plan
- **Reset clear.** `ADDR_WIDTH`=4 (DEPTH=4). Preload is irrelevant. Release `rst`, then assert `req` continuously. Required:
  - `ready`=0 for 3 cycles, 1 from edge 4.
  - No `rvalid` before edge 5.
  - Word loads of 0x0, 0x4, 0x8, 0xC all return 0x00000000.
- **Byte lanes.** Store word 0xDEADBEEF at 0x10. Store byte `MDin`=0x55 at 0x12. Required:
  - Word load at 0x10 returns 0xDE55BEEF.
  - Half load at 0x12 returns 0x0000DE55 with `sign_ext`=0 and 0xFFFFDE55 with `sign_ext`=1.
- **Sign extension.** After the previous scenario:
  - Byte load at 0x11, `sign_ext`=1, returns 0xFFFFFFBE.
  - Byte load at 0x10, `sign_ext`=0, returns 0x000000EF.
- **Illegal accesses.**
  - Word store 0x12345678 at 0x13 gives `rvalid`=1 and `err`=1; a following word load at 0x10 is still 0xDE55BEEF.
  - Half load at 0x11 gives `err`=1 with `data` unchanged.
  - A request with `size`=11 gives `err`=1.
- **Back-to-back.** Store 0xA5A5A5A5 at 0x20 on edge N, load 0x20 on edge N+1. Required:
  - `rvalid` high after edges N+1 and N+2.
  - `data`=0xA5A5A5A5 after edge N+2.
- **Reset mid-clear.** `ADDR_WIDTH`=6 (DEPTH=16). Assert `rst` at edge 5 of the clear. Required:
  - Outputs return to reset values immediately.
  - After release, `ready` rises exactly 16 edges later.
  - A `req` held during the clear produces no `rvalid`.
